// File: rtl/vend_pkg.sv
// Shared definitions for the vending controller: FSM state encodings and coin values.
package vend_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'b001,
    ST_COLLECT = 3'b010,
    ST_CHANGE  = 3'b100
  } state_e;

  localparam int unsigned HALF = 1;
  localparam int unsigned ONE  = 2;

endpackage

// File: rtl/vend_change_pulser.sv
// Loadable down-counter that emits one registered pulse per count while enabled.
module vend_change_pulser #(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          en,
  output logic          pulse,
  output logic          done
);

  logic [CW-1:0] count_q, count_d;
  logic          pulse_q, pulse_d;

  always_comb begin
    count_d = count_q;
    pulse_d = 1'b0;
    if (load) begin
      count_d = load_val;
    end else if (en && (count_q != '0)) begin
      count_d = count_q - 1'b1;
      pulse_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      pulse_q <= 1'b0;
    end else begin
      count_q <= count_d;
      pulse_q <= pulse_d;
    end
  end

  // Last coin is going out this cycle; the FSM leaves CHANGE on this edge.
  assign done  = (count_q == CW'(1));
  assign pulse = pulse_q;

endmodule

// File: rtl/vend_ctrl.sv
// Coin-operated vending controller: accumulates credit, dispenses, refunds change.
module vend_ctrl
  import vend_pkg::*;
#(
  parameter int PRICE = 5,
  parameter int CW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pi_money_half,
  input  logic          pi_money_one,
  input  logic          pi_cancel,
  output logic          po_cola,
  output logic          po_change,
  output logic          po_reject,
  output logic          po_busy,
  output logic [CW-1:0] po_credit
);

  state_e        state_q, state_d;
  logic [CW-1:0] credit_q, credit_d;
  logic          cola_q, cola_d;
  logic          reject_q, reject_d;

  logic [CW:0]   inc;
  logic [CW:0]   sum;
  logic [CW-1:0] rem;
  logic          load;
  logic [CW-1:0] load_val;
  logic          chg_done;

  always_comb begin
    inc = (pi_money_half ? (CW+1)'(HALF) : '0) + (pi_money_one ? (CW+1)'(ONE) : '0);
    sum = {1'b0, credit_q} + inc;
    // Only used once sum >= PRICE, so the top bit of sum is known to be zero.
    rem = sum[CW-1:0] - CW'(PRICE);
  end

  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    cola_d   = 1'b0;
    reject_d = 1'b0;
    load     = 1'b0;
    load_val = '0;
    case (state_q)
      ST_IDLE, ST_COLLECT: begin
        if (pi_cancel && ((state_q == ST_COLLECT) || (inc != '0))) begin
          load     = 1'b1;
          load_val = sum[CW-1:0];
          credit_d = '0;
          state_d  = ST_CHANGE;
        end else if (sum >= (CW+1)'(PRICE)) begin
          cola_d   = 1'b1;
          load     = 1'b1;
          load_val = rem;
          credit_d = '0;
          state_d  = (rem != '0) ? ST_CHANGE : ST_IDLE;
        end else if (inc != '0) begin
          credit_d = sum[CW-1:0];
          state_d  = ST_COLLECT;
        end
      end
      ST_CHANGE: begin
        reject_d = (inc != '0);
        if (chg_done) state_d = ST_IDLE;
      end
      default: begin
        state_d  = ST_IDLE;
        credit_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      credit_q <= '0;
      cola_q   <= 1'b0;
      reject_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      cola_q   <= cola_d;
      reject_q <= reject_d;
    end
  end

  vend_change_pulser #(.CW(CW)) u_pulser (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_val (load_val),
    .en       (state_q == ST_CHANGE),
    .pulse    (po_change),
    .done     (chg_done)
  );

  assign po_cola   = cola_q;
  assign po_reject = reject_q;
  assign po_busy   = (state_q == ST_CHANGE);
  assign po_credit = credit_q;

endmodule

// File: tb/tb_vend_ctrl.sv
// Bench for vend_ctrl: directed scenarios plus random traffic against a credit/refund model.
module tb_vend_ctrl;

  localparam int PRICE = 5;
  localparam int CW    = 4;
  localparam int W     = 4 + CW;

  logic          clk;
  logic          rst;
  logic          pi_money_half;
  logic          pi_money_one;
  logic          pi_cancel;
  logic          po_cola;
  logic          po_change;
  logic          po_reject;
  logic          po_busy;
  logic [CW-1:0] po_credit;

  int n_checks;
  int n_fail;

  // Reference model: credit held and coins still owed to the customer.
  int m_credit;
  int m_owed;

  logic [W-1:0] exp_q[$];

  vend_ctrl #(.PRICE(PRICE), .CW(CW)) dut (
    .clk           (clk),
    .rst           (rst),
    .pi_money_half (pi_money_half),
    .pi_money_one  (pi_money_one),
    .pi_cancel     (pi_cancel),
    .po_cola       (po_cola),
    .po_change     (po_change),
    .po_reject     (po_reject),
    .po_busy       (po_busy),
    .po_credit     (po_credit)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, got no finish, required finish");
    $fatal(1);
  end

  function automatic logic [W-1:0] obs_vec();
    return {po_cola, po_change, po_reject, po_busy, po_credit};
  endfunction

  // Driver: apply one cycle of inputs, predict the outputs after the edge, sample at +1.
  task automatic step(input logic h, input logic o, input logic c, input logic r);
    int   value;
    logic e_cola, e_chg, e_rej;
    pi_money_half = h;
    pi_money_one  = o;
    pi_cancel     = c;
    rst           = r;
    value  = int'(h) + 2 * int'(o);
    e_cola = 1'b0;
    e_chg  = 1'b0;
    e_rej  = 1'b0;
    if (r) begin
      m_credit = 0;
      m_owed   = 0;
    end else if (m_owed > 0) begin
      e_chg  = 1'b1;
      m_owed = m_owed - 1;
      e_rej  = (value > 0);
    end else if (c && (m_credit + value > 0)) begin
      m_owed   = m_credit + value;
      m_credit = 0;
    end else if (m_credit + value >= PRICE) begin
      e_cola   = 1'b1;
      m_owed   = m_credit + value - PRICE;
      m_credit = 0;
    end else begin
      m_credit = m_credit + value;
    end
    exp_q.push_back({e_cola, e_chg, e_rej, (m_owed > 0), CW'(m_credit)});
    @(posedge clk);
    #1;
    pi_money_half = 1'b0;
    pi_money_one  = 1'b0;
    pi_cancel     = 1'b0;
    rst           = 1'b0;
  endtask

  task automatic test_reset();
    logic [W-1:0] e;
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b1, 1'b1, 1'b1);
      e = exp_q.pop_front();
      n_checks++;
      if (obs_vec() !== e || obs_vec() !== '0) begin
        n_fail++;
        $display("FAIL reset cycle %0d: got %b required %b", i, obs_vec(), e);
      end
    end
  endtask

  task automatic test_five_halves();
    logic [W-1:0] e;
    int colas, chgs;
    colas = 0;
    chgs  = 0;
    step(1'b0, 1'b0, 1'b0, 1'b1);
    void'(exp_q.pop_front());
    for (int i = 0; i < 12; i++) begin
      step((i % 2 == 0) && (i < 10), 1'b0, 1'b0, 1'b0);
      e = exp_q.pop_front();
      n_checks++;
      if (obs_vec() !== e) begin
        n_fail++;
        $display("FAIL five_halves cycle %0d: got %b required %b", i, obs_vec(), e);
      end
      colas += int'(po_cola);
      chgs  += int'(po_change);
      if (i == 6) begin
        n_checks++;
        if (po_credit !== CW'(4)) begin
          n_fail++;
          $display("FAIL five_halves credit: got %0d required 4", po_credit);
        end
      end
      if (i == 8) begin
        n_checks++;
        if (po_cola !== 1'b1 || po_credit !== '0 || po_busy !== 1'b0) begin
          n_fail++;
          $display("FAIL five_halves dispense: got cola=%b credit=%0d busy=%b required 1/0/0",
                   po_cola, po_credit, po_busy);
        end
      end
    end
    n_checks++;
    if (colas != 1 || chgs != 0) begin
      n_fail++;
      $display("FAIL five_halves totals: got cola=%0d change=%0d required 1/0", colas, chgs);
    end
  endtask

  task automatic test_three_ones();
    logic [W-1:0] e;
    int colas, chgs, busys;
    colas = 0;
    chgs  = 0;
    busys = 0;
    for (int i = 0; i < 7; i++) begin
      step(1'b0, (i < 3), 1'b0, 1'b0);
      e = exp_q.pop_front();
      n_checks++;
      if (obs_vec() !== e) begin
        n_fail++;
        $display("FAIL three_ones cycle %0d: got %b required %b", i, obs_vec(), e);
      end
      colas += int'(po_cola);
      chgs  += int'(po_change);
      busys += int'(po_busy);
      if (i == 3) begin
        n_checks++;
        if (po_change !== 1'b1) begin
          n_fail++;
          $display("FAIL three_ones change latency: got %b required 1", po_change);
        end
      end
    end
    n_checks++;
    if (colas != 1 || chgs != 1 || busys != 1) begin
      n_fail++;
      $display("FAIL three_ones totals: got cola=%0d change=%0d busy=%0d required 1/1/1",
               colas, chgs, busys);
    end
  endtask

  task automatic test_half_one_pair();
    logic [W-1:0] e;
    int colas, chgs;
    colas = 0;
    chgs  = 0;
    for (int i = 0; i < 6; i++) begin
      step((i < 2), (i < 2), 1'b0, 1'b0);
      e = exp_q.pop_front();
      n_checks++;
      if (obs_vec() !== e) begin
        n_fail++;
        $display("FAIL half_one cycle %0d: got %b required %b", i, obs_vec(), e);
      end
      colas += int'(po_cola);
      chgs  += int'(po_change);
      if (i == 0) begin
        n_checks++;
        if (po_credit !== CW'(3)) begin
          n_fail++;
          $display("FAIL half_one credit: got %0d required 3", po_credit);
        end
      end
    end
    n_checks++;
    if (colas != 1 || chgs != 1) begin
      n_fail++;
      $display("FAIL half_one totals: got cola=%0d change=%0d required 1/1", colas, chgs);
    end
  endtask

  // Build credit 4, then cancel with an optional same-cycle one-coin.
  task automatic test_cancel(input logic with_coin, input int want);
    logic [W-1:0] e;
    int colas, chgs;
    colas = 0;
    chgs  = 0;
    for (int i = 0; i < 12; i++) begin
      step(1'b0, (i < 2) || (i == 2 && with_coin), (i == 2), 1'b0);
      e = exp_q.pop_front();
      n_checks++;
      if (obs_vec() !== e) begin
        n_fail++;
        $display("FAIL cancel cycle %0d: got %b required %b", i, obs_vec(), e);
      end
      colas += int'(po_cola);
      chgs  += int'(po_change);
    end
    n_checks++;
    if (colas != 0 || chgs != want || po_credit !== '0 || po_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL cancel totals: got cola=%0d change=%0d credit=%0d busy=%b required 0/%0d/0/0",
               colas, chgs, po_credit, po_busy, want);
    end
  endtask

  task automatic test_reject_and_reset();
    logic [W-1:0] e;
    int chgs, rejs;
    chgs = 0;
    rejs = 0;
    // credit 4, cancel, coin inserted while refunding
    for (int i = 0; i < 10; i++) begin
      step((i == 4), (i < 2) || (i == 5), (i == 2) || (i == 5), 1'b0);
      e = exp_q.pop_front();
      n_checks++;
      if (obs_vec() !== e) begin
        n_fail++;
        $display("FAIL reject cycle %0d: got %b required %b", i, obs_vec(), e);
      end
      chgs += int'(po_change);
      rejs += int'(po_reject);
    end
    n_checks++;
    if (chgs != 4 || rejs != 2) begin
      n_fail++;
      $display("FAIL reject totals: got change=%0d reject=%0d required 4/2", chgs, rejs);
    end
    // credit 4, cancel, reset after two pulses
    chgs = 0;
    for (int i = 0; i < 9; i++) begin
      step(1'b0, (i < 2) || (i == 5), (i == 2), (i == 5));
      e = exp_q.pop_front();
      n_checks++;
      if (obs_vec() !== e) begin
        n_fail++;
        $display("FAIL mid_reset cycle %0d: got %b required %b", i, obs_vec(), e);
      end
      if (i >= 5) chgs += int'(po_change) + int'(po_busy) + int'(po_reject);
    end
    n_checks++;
    if (chgs != 0) begin
      n_fail++;
      $display("FAIL mid_reset activity: got %0d active outputs after reset required 0", chgs);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] e;
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 9) == 0), ($urandom_range(0, 59) == 0));
      e = exp_q.pop_front();
      n_checks++;
      if (obs_vec() !== e) begin
        n_fail++;
        $display("FAIL random cycle %0d: got %b required %b", i, obs_vec(), e);
      end
    end
  endtask

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    m_credit      = 0;
    m_owed        = 0;
    rst           = 1'b1;
    pi_money_half = 1'b0;
    pi_money_one  = 1'b0;
    pi_cancel     = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_five_halves();
    test_three_ones();
    test_half_one_pair();
    test_cancel(1'b0, 4);
    test_cancel(1'b1, 6);
    test_reject_and_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
